// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation code type and the 4-bit codes issued by the ALU
// control unit. An operation code is {Ainvert, Bnegate, Op[1:0]}.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_SLT = 4'b0111;
  localparam alu_op_t ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_slice.sv
// One bit of the ripple ALU.
//   a, b     : operand bits
//   less     : SLT input (MSB Set for bit 0, 0 elsewhere)
//   ainvert  : invert a before the logic/adder
//   binvert  : invert b before the logic/adder
//   cin      : carry in
//   op       : 00 AND, 01 OR, 10 sum, 11 less
//   result   : selected output bit
//   cout     : carry out
//   set      : sign of the true difference (IS_MSB only, else 0)
//   overflow : signed overflow of this slice (IS_MSB only, else 0)
module alu_slice #(
  parameter bit IS_MSB = 1'b0
) (
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout,
  output logic       set,
  output logic       overflow
);

  logic ai, bi, sum;

  assign ai   = a ^ ainvert;
  assign bi   = b ^ binvert;
  assign sum  = ai ^ bi ^ cin;
  assign cout = (ai & bi) | (cin & (ai ^ bi));

  always_comb begin
    result = 1'b0;
    case (op)
      2'b00:   result = ai & bi;
      2'b01:   result = ai | bi;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

  if (IS_MSB) begin : g_msb
    assign overflow = cin ^ cout;
    // Correcting the sign bit by overflow keeps SLT right when a-b overflows.
    assign set      = sum ^ (cin ^ cout);
  end else begin : g_mid
    assign overflow = 1'b0;
    assign set      = 1'b0;
  end

endmodule

// File: rtl/alu_64bit.sv
// 64-bit RISC-V datapath ALU: ripple chain of alu_slice instances followed by a
// one-cycle output register (result, overflow, zero).
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (result=0, overflow=0, zero=1)
//   a, b      : two's complement operands
//   operation : alu_op_t, {Ainvert, Bnegate, Op[1:0]}
//   result    : registered result
//   overflow  : registered signed overflow (ADD/SUB only)
//   zero      : registered, set when result is 0
// Build option: define ALU_NOR_EN to enable code 1100 (NOR); otherwise it yields 0.
module alu_64bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64  // must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          operation,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  logic             ainvert, bnegate;
  logic [1:0]       op;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] slice_result;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] ovf_vec;
  logic             slt_set, slice_ovf;

  logic [WIDTH-1:0] result_d, result_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;

  assign ainvert  = operation[3];
  assign bnegate  = operation[2];
  assign op       = operation[1:0];
  assign carry[0] = bnegate;

  // Only the MSB slice drives set/overflow; the others tie them to 0.
  assign slt_set   = |set_vec;
  assign slice_ovf = |ovf_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_slice #(
      .IS_MSB(i == WIDTH - 1)
    ) u_slice (
      .a       (a[i]),
      .b       (b[i]),
      .less    ((i == 0) ? slt_set : 1'b0),
      .ainvert (ainvert),
      .binvert (bnegate),
      .cin     (carry[i]),
      .op      (op),
      .result  (slice_result[i]),
      .cout    (carry[i+1]),
      .set     (set_vec[i]),
      .overflow(ovf_vec[i])
    );
  end

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (operation)
      ALU_AND, ALU_OR, ALU_SLT: result_d = slice_result;
      ALU_ADD, ALU_SUB: begin
        result_d   = slice_result;
        overflow_d = slice_ovf;
      end
`ifdef ALU_NOR_EN
      ALU_NOR: result_d = slice_result;
`endif
      default: ;
    endcase
    zero_d = ~|result_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_64bit.sv
// Directed bench for alu_64bit with hand-computed expected values.
module tb_alu_64bit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a, b;
  alu_op_t     operation;
  logic [63:0] result;
  logic        overflow, zero;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] MaxPos = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;

  alu_64bit #(
    .WIDTH(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .operation(operation),
    .result   (result),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one operation away from the edge, then sample just after the capturing edge.
  task automatic run(input string tag, input alu_op_t opc, input logic [63:0] va,
                     input logic [63:0] vb, input logic [63:0] exp_res,
                     input logic exp_ovf, input logic exp_zero);
    @(negedge clk);
    operation = opc;
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check({tag, ".res"}, result, exp_res);
    check({tag, ".ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
    check({tag, ".zero"}, {63'd0, zero}, {63'd0, exp_zero});
  endtask

  initial begin
    rst = 1'b1;
    a = 64'd123;
    b = 64'd4;
    operation = ALU_ADD;
    @(posedge clk);
    #1;
    check("reset.res", result, 64'd0);
    check("reset.ovf", {63'd0, overflow}, 64'd0);
    check("reset.zero", {63'd0, zero}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run("add",      ALU_ADD, 64'd123, 64'd4,     64'd127, 1'b0, 1'b0);
    run("sub_eq",   ALU_SUB, 64'd254, 64'd254,   64'd0,   1'b0, 1'b1);
    run("sub_neg",  ALU_SUB, 64'd20,  64'd111,   64'hFFFF_FFFF_FFFF_FFA5, 1'b0, 1'b0);
    run("and",      ALU_AND, 64'd10,  64'd12,    64'd8,   1'b0, 1'b0);
    run("or",       ALU_OR,  64'd10,  64'd12,    64'd14,  1'b0, 1'b0);
    run("slt_lt",   ALU_SLT, 64'd123, 64'd10242, 64'd1,   1'b0, 1'b0);
    run("slt_ge",   ALU_SLT, 64'd10242, 64'd123, 64'd0,   1'b0, 1'b1);
    run("add_ovf",  ALU_ADD, MaxPos,  64'd1,     MinNeg,  1'b1, 1'b0);
    run("add_mix",  ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFB, 64'd12, 64'd7, 1'b0, 1'b0);
    run("sub_wrap", ALU_SUB, MinNeg,  64'd1,     MaxPos,  1'b1, 1'b0);
    // a-b overflows here; SLT must still report MinNeg < 1 and never flag overflow.
    run("slt_ovf",  ALU_SLT, MinNeg,  64'd1,     64'd1,   1'b0, 1'b0);
    run("slt_neg",  ALU_SLT, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);
    run("and_ovf0", ALU_AND, MaxPos,  MaxPos,    MaxPos,  1'b0, 1'b0);
    run("bad_op",   4'b0011, 64'd10,  64'd12,    64'd0,   1'b0, 1'b1);
`ifdef ALU_NOR_EN
    run("nor",      ALU_NOR, 64'd10,  64'd12,    64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
`else
    run("nor_off",  ALU_NOR, 64'd10,  64'd12,    64'd0,   1'b0, 1'b1);
`endif

    // Mid-stream reset: leave a non-zero overflowing result, then reset on one edge.
    run("pre_rst",  ALU_ADD, MaxPos,  64'd1,     MinNeg,  1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    operation = ALU_ADD;
    a = MaxPos;
    b = 64'd5;
    @(posedge clk);
    #1;
    check("mid_rst.res", result, 64'd0);
    check("mid_rst.ovf", {63'd0, overflow}, 64'd0);
    check("mid_rst.zero", {63'd0, zero}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", ALU_ADD, 64'd1,   64'd2,     64'd3,   1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
